// File: rtl/bw_multiplier_signed.sv
// Signed Baugh-Wooley multiplier with a registered 2*numBit product.
// Define BW_MULT_IN_REG_EN to add operand input registers (2-cycle latency).
module bw_multiplier_signed #(
    parameter int numBit = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [numBit-1:0]   m_in,
    input  logic [numBit-1:0]   n_in,
    output logic [2*numBit-1:0] o_out
);

    localparam int W = 2 * numBit;

    logic [numBit-1:0] m_op;
    logic [numBit-1:0] n_op;
    logic [W-1:0]      product;

`ifdef BW_MULT_IN_REG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            m_op <= '0;
            n_op <= '0;
        end else begin
            m_op <= m_in;
            n_op <= n_in;
        end
    end
`else
    assign m_op = m_in;
    assign n_op = n_in;
`endif

    // Rows are folded into a sum/carry pair with full adders; a ripple
    // adder resolves the pair. Carries above bit W-1 fall off the top.
    function automatic logic [W-1:0] bw_product(
        input logic [numBit-1:0] m,
        input logic [numBit-1:0] n
    );
        logic [W-1:0] row;
        logic [W-1:0] s;
        logic [W-1:0] c;
        logic [W-1:0] s_n;
        logic [W-1:0] c_n;
        logic [W-1:0] res;
        logic         cy;
        s = '0;
        c = '0;
        for (int i = 0; i < numBit; i++) begin
            row = '0;
            for (int j = 0; j < numBit; j++) begin
                if ((i == numBit - 1) != (j == numBit - 1))
                    row[i + j] = ~(m[j] & n[i]);
                else
                    row[i + j] = m[j] & n[i];
            end
            s_n = s ^ c ^ row;
            c_n = ((s & c) | (s & row) | (c & row)) << 1;
            s   = s_n;
            c   = c_n;
        end
        row            = '0;
        row[numBit]    = 1'b1;
        row[W - 1]     = 1'b1;
        s_n = s ^ c ^ row;
        c_n = ((s & c) | (s & row) | (c & row)) << 1;
        res = '0;
        cy  = 1'b0;
        for (int b = 0; b < W; b++) begin
            res[b] = s_n[b] ^ c_n[b] ^ cy;
            cy     = (s_n[b] & c_n[b]) | (s_n[b] & cy) | (c_n[b] & cy);
        end
        return res;
    endfunction

    always_comb begin
        product = bw_product(m_op, n_op);
    end

    always_ff @(posedge clk) begin
        if (rst)
            o_out <= '0;
        else
            o_out <= product;
    end

endmodule

// File: tb/tb_bw_multiplier_signed.sv
// Scoreboard bench for bw_multiplier_signed at numBit=8.
// Directed vectors, mid-stream reset, and a full operand sweep.
module tb_bw_multiplier_signed;

`ifdef BW_MULT_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst;
    logic [7:0]  m_in;
    logic [7:0]  n_in;
    logic [15:0] o_out;

    typedef struct {
        logic [15:0] val;
        int          due;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    bw_multiplier_signed #(.numBit(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .m_in  (m_in),
        .n_in  (n_in),
        .o_out (o_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        logic signed [15:0] p;
        sa = {{8{a[7]}}, a};
        sb = {{8{b[7]}}, b};
        p  = sa * sb;
        return p;
    endfunction

    // Monitor: compare every expectation that falls due this cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                n_checks++;
                if (e.due != cyc || o_out !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: cycle %0d got %h expected %h (due %0d)",
                             e.name, cyc, o_out, e.val, e.due);
                end
            end
        end
    end

    task automatic drive(input logic [7:0] m, input logic [7:0] n,
                         input logic r, input logic chk,
                         input logic [15:0] e, input string nm);
        @(negedge clk);
        m_in = m;
        n_in = n;
        rst  = r;
        if (r) begin
            // Anything not yet on the output when reset lands is lost.
            while (q.size() > 0 && q[$].due >= cyc + 1)
                void'(q.pop_back());
            q.push_back('{16'h0000, cyc + 1, nm});
        end else if (chk) begin
            q.push_back('{e, cyc + LAT, nm});
        end
    endtask

    initial begin
        rst  = 1'b1;
        m_in = 8'h00;
        n_in = 8'h00;

        drive(8'h12, 8'h34, 1'b1, 1'b1, 16'h0000, "reset0");
        drive(8'h12, 8'h34, 1'b1, 1'b1, 16'h0000, "reset1");
        drive(8'h00, 8'h55, 1'b0, 1'b1, 16'h0000, "zero_x_55");
        drive(8'h80, 8'h80, 1'b0, 1'b1, 16'h4000, "min_x_min");
        drive(8'h80, 8'h7F, 1'b0, 1'b1, 16'hC080, "min_x_max");
        drive(8'h7F, 8'h7F, 1'b0, 1'b1, 16'h3F01, "max_x_max");
        drive(8'hFF, 8'hFF, 1'b0, 1'b1, 16'h0001, "neg1_x_neg1");
        drive(8'hFF, 8'h01, 1'b0, 1'b1, 16'hFFFF, "neg1_x_1");
        drive(8'h55, 8'h00, 1'b0, 1'b1, 16'h0000, "55_x_zero");

        drive(8'h03, 8'h06, 1'b0, 1'b1, 16'h0012, "b2b_3x6");
        drive(8'hFD, 8'h06, 1'b1, 1'b1, 16'h0000, "b2b_reset");
        drive(8'hFD, 8'h06, 1'b0, 1'b1, 16'hFFEE, "b2b_m3x6");

        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                drive(8'(a), 8'(b), 1'b0, 1'b1, model(8'(a), 8'(b)), "sweep");
            end
        end

        for (int k = 0; k < LAT + 3; k++)
            drive(8'h00, 8'h00, 1'b0, 1'b0, 16'h0000, "idle");

        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations never came due, required 0",
                     q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bw_multiplier_signed.md
Name: bw_multiplier_signed

Overview:
- Parameterised two's-complement signed multiplier using the Baugh-Wooley partial-product array.
- Takes two numBit-wide signed operands and returns the full 2*numBit-wide signed product on a registered output.
- Arithmetic leaf block for datapaths that need exact signed products with no overflow.

Parameters:
- numBit, 8, operand width in bits; legal range 2..32; product width is 2*numBit.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- m_in  input  numBit  multiplicand, two's complement signed.
- n_in  input  numBit  multiplier, two's complement signed.
- o_out  output  2*numBit  product register, two's complement signed.

Behaviour:
- Reset: rst is synchronous and active-high. With rst=1 at a rising clk edge, o_out becomes 0 and any internal pipeline registers become 0. rst wins over new data in the same cycle.
- Latency: 1 clk. o_out after edge k equals $signed(m_in)*$signed(n_in) sampled at edge k.
- Throughput: one product per cycle. No handshake and no valid signal; the output register loads every non-reset cycle.
- Array construction, for operand bits i, j in 0..numBit-1:
  - pp[i][j] = m_in[j] & n_in[i] when both i and j are below numBit-1, or when both equal numBit-1.
  - pp[i][j] = ~(m_in[j] & n_in[i]) when exactly one of i, j equals numBit-1.
  - Each pp[i][j] carries weight 2^(i+j).
- Correction constants: add constant 1 at bit weight numBit and constant 1 at bit weight 2*numBit-1.
- Summation:
  - Carry-save array of full and half adders reduces the array row by row; a final ripple-carry adder produces the result.
  - The carry out of bit 2*numBit-1 is discarded.
  - The result is exact for all operand pairs; no saturation, no overflow flag.
- Boundary values:
  - (-2^(numBit-1)) * (-2^(numBit-1)) = +2^(2*numBit-2); this is representable and must be exact.
  - Zero on either operand gives 0.
  - -1 * -1 gives +1.
- The adder array is combinational. Behavioural "*" must not be used for the datapath; it may appear in assertions only.
- Reset mid-stream: the product of the operands at the reset edge is lost. The first valid product appears 1 cycle after rst deasserts.

Optional Feature:
- Macro: BW_MULT_IN_REG_EN.
- Defined:
  - m_in and n_in are captured in input registers, which reset to 0.
  - The array computes from those registers; o_out stays registered.
  - Latency becomes 2 clk; throughput stays one per cycle.
  - Reset clears both register stages.
- Undefined: no input registers; latency 1 clk as specified above.

Test Plan:
- numBit=8, rst held 2 cycles -> o_out=0x0000. Then m_in=0, n_in=0x55 -> o_out=0x0000 after 1 clk.
- m_in=0x80 (-128), n_in=0x80 (-128) -> o_out=0x4000 (+16384). m_in=0x80, n_in=0x7F -> o_out=0xC080 (-16256).
- m_in=0x7F, n_in=0x7F -> o_out=0x3F01 (16129). m_in=0xFF, n_in=0xFF -> o_out=0x0001. m_in=0xFF, n_in=0x01 -> o_out=0xFFFF.
- Exhaustive sweep of all 65536 (m_in, n_in) pairs, one per cycle -> every o_out equals $signed(m_in)*$signed(n_in) from the previous cycle; zero mismatches.
- Back-to-back 3 → 0x03*0x06=0x0012, 0xFD*0x06=0xFFEE; assert rst in cycle 2 -> o_out=0 that cycle, 0x0012 lost/overwritten correctly, next product valid 1 clk after rst drops.
- Re-run the first three scenarios with BW_MULT_IN_REG_EN defined -> same values, each appearing 2 clk after the inputs are applied.
